// File: rtl/alu_arbiter_pkg.sv
// Shared state encodings, ALU opcodes and sizing constants for the ALU sharing block.
package alu_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_EXEC = 2'd1;
  localparam logic [1:0] ARB_CAPT = 2'd2;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_MUL = 3'd3;

  // Wide enough for ALU_LAT up to 4.
  localparam int CNT_W = 3;

  localparam int CLOCK_PERIOD = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: search starts one past ptr and wraps.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is taken and advances ptr.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // First pass covers cores above ptr, second pass wraps to 0..ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (IDX_W'(j) > ptr)) begin
        any    = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any && req[j] && (IDX_W'(j) <= ptr)) begin
        any    = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between NUM_CORES cores with round-robin arbitration.
// Latency: grant one cycle after request, done ALU_LAT+1 cycles after grant.
// Backpressure: cores hold i_req until o_gnt; requests are only sampled while idle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int OP_W      = 3,
  parameter int ALU_LAT   = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CORES-1:0]        i_req,
  input  logic [NUM_CORES*DATA_W-1:0] i_in1,
  input  logic [NUM_CORES*DATA_W-1:0] i_in2,
  input  logic [NUM_CORES*OP_W-1:0]   i_op,
  output logic [NUM_CORES-1:0]        o_gnt,
  output logic [NUM_CORES-1:0]        o_done,
  output logic [DATA_W-1:0]           o_result,
  output logic                        o_z,
  output logic                        o_busy,
  output logic [DATA_W-1:0]           o_alu_in1,
  output logic [DATA_W-1:0]           o_alu_in2,
  output logic [OP_W-1:0]             o_alu_op,
  input  logic [DATA_W-1:0]           i_alu_out,
  input  logic                        i_alu_z
);

  localparam int IDX_W = $clog2(NUM_CORES);

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;

  logic [NUM_CORES-1:0] win_oh;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  logic [DATA_W-1:0]    sel_in1;
  logic [DATA_W-1:0]    sel_in2;
  logic [OP_W-1:0]      sel_op;
  logic [NUM_CORES-1:0] owner_oh;

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_rr (
    .req (i_req),
    .ptr (ptr),
    .gnt (win_oh),
    .idx (win_idx),
    .any (win_any)
  );

  // Operand mux for the current winner.
  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    sel_op  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (win_idx == IDX_W'(k)) begin
        sel_in1 = i_in1[k*DATA_W +: DATA_W];
        sel_in2 = i_in2[k*DATA_W +: DATA_W];
        sel_op  = i_op[k*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      owner_oh[k] = (owner == IDX_W'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      ptr       <= IDX_W'(NUM_CORES - 1);
      owner     <= '0;
      o_gnt     <= '0;
      o_done    <= '0;
      o_result  <= '0;
      o_z       <= 1'b0;
      o_busy    <= 1'b0;
      o_alu_in1 <= '0;
      o_alu_in2 <= '0;
      o_alu_op  <= OP_W'(ALU_NOP);
    end else begin
      o_gnt  <= '0;
      o_done <= '0;
      case (state)
        ARB_IDLE: begin
          if (win_any) begin
            o_alu_in1 <= sel_in1;
            o_alu_in2 <= sel_in2;
            o_alu_op  <= sel_op;
            owner     <= win_idx;
            ptr       <= win_idx;
            o_gnt     <= win_oh;
            cnt       <= CNT_W'(ALU_LAT);
            o_busy    <= 1'b1;
            state     <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          // ALU inputs stay untouched here so the ALU sees stable operands.
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ARB_CAPT;
          end
        end
        ARB_CAPT: begin
          o_result  <= i_alu_out;
          o_z       <= i_alu_z;
          o_done    <= owner_oh;
          o_alu_in1 <= '0;
          o_alu_in2 <= '0;
          o_alu_op  <= OP_W'(ALU_NOP);
          o_busy    <= 1'b0;
          state     <= ARB_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one clocked ALU between NUM_CORES requesting cores.
- Round-robin arbitration.
- Latches the winner's operands and drives the ALU for ALU_LAT cycles.
- Captures the result and returns it with a one-cycle done pulse to the owning core.
- Sits between the core execute stages and the single ALU instance.

Parameters:
NUM_CORES, 4, number of requesting cores (2..8)
DATA_W, 16, operand/result width
OP_W, 3, ALU opcode width
ALU_LAT, 1, clock edges between ALU input sample and valid i_alu_out (1..4)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_req  in  NUM_CORES  per-core request level
i_in1  in  NUM_CORES*DATA_W  packed operand A; core k at [k*DATA_W +: DATA_W]
i_in2  in  NUM_CORES*DATA_W  packed operand B, same packing
i_op  in  NUM_CORES*OP_W  packed opcodes
o_gnt  out  NUM_CORES  one-hot, one-cycle accept pulse
o_done  out  NUM_CORES  one-hot, one-cycle result-valid pulse
o_result  out  DATA_W  last captured result, broadcast
o_z  out  1  zero flag captured with o_result
o_busy  out  1  high when not IDLE
o_alu_in1  out  DATA_W  to ALU i_in1
o_alu_in2  out  DATA_W  to ALU i_in2
o_alu_op  out  OP_W  to ALU i_alu_op
i_alu_out  in  DATA_W  from ALU o_alu_out
i_alu_z  in  1  from ALU o_z

Behaviour:
- Interface: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- All outputs are registered. On i_rst, every output is 0, state is IDLE, and the RR pointer is NUM_CORES-1, so core 0 has top priority first.
- FSM states:
  - IDLE: if any i_req, pick the winner. Latch its in1/in2/op into the ALU output registers, record owner, pulse o_gnt[owner], load cnt=ALU_LAT, go to EXEC. With no request, stay in IDLE; ALU outputs hold 0 and o_alu_op=0 (NOP).
  - EXEC: ALU inputs are held stable. cnt decrements each edge. At cnt==1, go to CAPT.
  - CAPT: i_alu_out and i_alu_z are valid. At the edge, o_result<=i_alu_out, o_z<=i_alu_z, o_done[owner] pulses. ALU outputs return to 0/NOP. Go to IDLE.
- Timing:
  - o_gnt is visible the cycle after the req-sampled edge.
  - o_done is visible ALU_LAT+1 cycles after o_gnt.
  - Back-to-back throughput is one operation per ALU_LAT+2 cycles.
  - IDLE may grant in the same cycle that o_done is high.
- Round robin:
  - Search starts at (ptr+1) mod NUM_CORES and wraps.
  - ptr<=winner on grant.
  - A continuously requesting core cannot starve the others.
- Handshake:
  - A core holds i_req and operands stable until it sees o_gnt.
  - Operands are sampled only on the grant edge; later changes have no effect.
  - i_req is sampled only in IDLE. A req dropped before grant is simply not served.
  - A req dropped after grant still completes and gets o_done.
  - Re-request is allowed from the o_done cycle.
- o_result/o_z hold their value until the next CAPT.
- Reset mid-operation aborts the operation: no o_done, ALU driven to NOP the next cycle.
- Width: operands pass through unmodified; no arithmetic is done in this block.

Decomposition:
- Shared definitions.v:
  - state encodings `ARB_IDLE=2'd0, `ARB_EXEC=2'd1, `ARB_CAPT=2'd2
  - ALU opcodes `ALU_NOP=3'd0, `ALU_ADD=3'd1, `ALU_SUB=3'd2, `ALU_MUL=3'd3
  - `CLOCK for benches
- Sub-module rr_arbiter: combinational next-winner from req and ptr; outputs one-hot grant and index. Reusable for future memory/bus sharing.

Test Plan:
1. Core 1 alone: req with in1=10, in2=20, op=ADD -> o_gnt=0010 one cycle; o_done=0010 two cycles later (ALU_LAT=1); o_result=30, o_z=0.
2. All four req at once, each holding until its grant -> grants in order 0,1,2,3, spaced 3 cycles apart; each o_done matches its own operands.
3. Core 0 requests continuously and core 2 requests from cycle 0 -> grants alternate 0,2,0,2; core 2 waits at most one operation.
4. Core 3 SUB 25-21 -> o_result=4, o_z=0. Then SUB 5-5 -> o_result=0, o_z=1. o_alu_op=0 in every IDLE cycle.
5. Core 2 changes in1 to 99 and drops req the cycle after its grant (original in1=3, in2=25, op=ADD) -> result=28 from the latched operands; o_done still pulses for core 2.
6. Assert i_rst in the EXEC cycle -> next cycle o_busy=0, all outputs 0, no o_done. First request after reset from core 0 is granted first.
